// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fsm
//  Description : UART transmit frame controller. Accepts a parallel byte on
//                a valid strobe in IDLE and sequences one frame on TX_OUT:
//                start bit, Data_Width data bits LSB first, optional parity
//                bit, stop bit. One clock is one bit time. The data-phase bit
//                index is supplied by an external serializer counter whose
//                enable this block drives.
//
//  Ports
//    clk         in   1           baud-rate clock, rising-edge
//    RST         in   1           synchronous active-high reset
//    P_DATA      in   Data_Width  byte to transmit, latched on acceptance
//    Data_Valid  in   1           request strobe, honoured only in IDLE
//    PAR_EN      in   1           1 = append parity bit, latched on acceptance
//    PAR_TYP     in   1           0 = even, 1 = odd, latched on acceptance
//    Bit_Idx     in   3           data bit index from the serializer counter
//    Ser_Done    in   1           serializer counter at its terminal index
//    Ser_En      out  1           serializer counter enable (DATA state)
//    TX_OUT      out  1           serial line, idle high
//    Busy        out  1           high from START through STOP
//    Frame_Done  out  1           high during the STOP cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm #(
  // Must stay 8: the serializer counter index is only 3 bits wide.
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [2:0]            Bit_Idx,
  input  logic                  Ser_Done,
  output logic                  Ser_En,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Frame_Done
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [Data_Width-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic                  w_parity_bit;

  // Even parity makes the total count of ones even, so the parity bit is the
  // XOR of the data; odd parity inverts it.
  assign w_parity_bit = (^r_data) ^ r_par_typ;

  // --------------------------------------------------------------------------
  // State and frame-parameter registers. Requests are only looked at in
  // IDLE, so anything presented mid-frame is dropped and the latched byte and
  // parity settings stay fixed for the whole frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state   <= c_IDLE;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (Data_Valid) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= c_START;
          end
        end
        c_START: begin
          r_state <= c_DATA;
        end
        c_DATA: begin
          // The counter ran from 0 because Ser_En was low in START, so its
          // terminal flag marks the last data bit.
          if (Ser_Done) begin
            r_state <= r_par_en ? c_PARITY : c_STOP;
          end
        end
        c_PARITY: begin
          r_state <= c_STOP;
        end
        c_STOP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode, purely from the state register, the latched byte and the
  // external bit index.
  // --------------------------------------------------------------------------
  always_comb begin
    Ser_En     = 1'b0;
    TX_OUT     = 1'b1;
    Busy       = 1'b0;
    Frame_Done = 1'b0;
    case (r_state)
      c_IDLE: begin
        TX_OUT = 1'b1;
      end
      c_START: begin
        TX_OUT = 1'b0;
        Busy   = 1'b1;
      end
      c_DATA: begin
        Ser_En = 1'b1;
        TX_OUT = r_data[Bit_Idx];
        Busy   = 1'b1;
      end
      c_PARITY: begin
        TX_OUT = w_parity_bit;
        Busy   = 1'b1;
      end
      c_STOP: begin
        TX_OUT     = 1'b1;
        Busy       = 1'b1;
        Frame_Done = 1'b1;
      end
      default: begin
        TX_OUT = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fsm
//  Description : Self-checking bench for uart_tx_fsm. Frame records (inputs
//                plus the expected serial bit pattern) are held in a table;
//                each accepted request pushes its expected per-cycle outputs
//                onto a scoreboard queue, and a monitor pops and compares one
//                entry per clock. Cycles with nothing queued must show idle
//                outputs. A small model of the serializer bit counter drives
//                Bit_Idx and Ser_Done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm;

  logic       clk;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [2:0] Bit_Idx;
  logic       Ser_Done;
  logic       Ser_En;
  logic       TX_OUT;
  logic       Busy;
  logic       Frame_Done;

  uart_tx_fsm #(.Data_Width(8)) u_dut (
    .clk        (clk),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Bit_Idx    (Bit_Idx),
    .Ser_Done   (Ser_Done),
    .Ser_En     (Ser_En),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .Frame_Done (Frame_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer bit counter: holds 0 while disabled, counts while enabled.
  logic [2:0] r_cnt;
  always @(posedge clk) begin
    if (RST || !Ser_En) r_cnt <= 3'd0;
    else                r_cnt <= r_cnt + 3'd1;
  end
  assign Bit_Idx  = r_cnt;
  assign Ser_Done = (r_cnt == 3'd7);

  // Expected outputs for one clock: {tx, busy, ser_en, frame_done}
  typedef struct packed {
    logic tx;
    logic busy;
    logic sen;
    logic fd;
  } exp_t;

  // bits[c] is TX_OUT in frame cycle c (c = 0 is the start bit)
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int          len;
    logic [10:0] bits;
  } vec_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  logic mon_en;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {tx,busy,sen,fd}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // One comparison per clock, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("frame_cycle", {TX_OUT, Busy, Ser_En, Frame_Done}, e);
      end else begin
        check("idle_cycle", {TX_OUT, Busy, Ser_En, Frame_Done}, 4'b1000);
      end
    end
  end

  task automatic push_frame(input vec_t v);
    for (int c = 0; c < v.len; c++) begin
      exp_t e;
      e.tx   = v.bits[c];
      e.busy = 1'b1;
      e.sen  = (c >= 1) && (c <= 8);
      e.fd   = (c == v.len - 1);
      q.push_back(e);
    end
  endtask

  // Called just after a rising edge; raises the request for one edge and
  // queues the expected frame once it has been accepted.
  task automatic send(input vec_t v);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    push_frame(v);
    Data_Valid = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    // 0xA5 no parity / 0x07 even / 0xA5 odd / 0x3C / 0xC3 / 0x55 /
    // 0x00 odd / 0xFF even
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b01101001010};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 11, 11'b11000001110};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'b11101001010};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 10, 11'b01001111000};
    tbl[4] = '{8'hC3, 1'b0, 1'b0, 10, 11'b01110000110};
    tbl[5] = '{8'h55, 1'b0, 1'b0, 10, 11'b01010101010};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 11, 11'b11000000000};
    tbl[7] = '{8'hFF, 1'b1, 1'b0, 11, 11'b10111111110};

    n_cmp      = 0;
    n_err      = 0;
    mon_en     = 1'b0;
    // A request held during reset must not start a frame.
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'h5A;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    RST        = 1'b0;
    Data_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Plain frames from the table
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 3 || i == 4 || i == 5) continue;
      send(tbl[i]);
      repeat (tbl[i].len + 2) @(posedge clk);
      #1;
    end

    // Odd parity with a request (and changed inputs) during DATA: dropped.
    send(tbl[2]);
    repeat (4) @(posedge clk);
    #1;
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Back-to-back: second request during the first IDLE cycle.
    send(tbl[3]);
    repeat (tbl[3].len) @(posedge clk);
    #1;
    send(tbl[4]);
    repeat (tbl[4].len + 2) @(posedge clk);
    #1;

    // Reset while Bit_Idx = 4, then a fresh 0x55 frame.
    send(tbl[0]);
    repeat (5) @(posedge clk);
    #1;
    if (Bit_Idx !== 3'd4) begin
      n_cmp++;
      n_err++;
      $display("FAIL reset_point_idx: got %0d expected 4", Bit_Idx);
    end
    RST = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    RST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(tbl[5]);
    repeat (tbl[5].len + 2) @(posedge clk);
    #1;

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: got %0d entries left expected 0", q.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
